// File: rtl/ps2_pkg.sv
// Shared types, constants and scan-code lookup
// for the PS/2 key event controller.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT  = 8'hE0;
   localparam logic [7:0] PS2_BRK  = 8'hF0;
   localparam int         NUM_KEYS = 12;

   localparam logic [7:0] KEY_CODES [NUM_KEYS] = '{
      8'h15, 8'h1C, 8'h1D, 8'h1B,
      8'h24, 8'h23, 8'h2D, 8'h2B,
      8'h2C, 8'h34, 8'h35, 8'h33
   };

   typedef struct packed {
      logic       vld;
      logic [3:0] idx;
   } key_hit_t;

   function automatic key_hit_t code_to_idx(
      input logic [7:0] code
   );
      key_hit_t h;
      h = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (code == KEY_CODES[i]) begin
            h.vld = 1'b1;
            h.idx = 4'(i);
         end
      end
      return h;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO with flush;
// head reads as zero while empty.
module ps2_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // storage, pointers (natural power-of-two wrap) and occupancy
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-byte sequencer: prefix FSM, key state,
// prefix timeout, error count and event FIFO.
module ps2_key_event_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 250000,
   parameter bit REPEAT_EN   = 1'b0
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CLEAR,
   input  logic        RX_VALID,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_ERR,
   output logic        EVT_VALID,
   input  logic        EVT_READY,
   output logic [3:0]  EVT_KEY,
   output logic        EVT_MAKE,
   output logic [11:0] KEY_STATE,
   output logic        OVERFLOW,
   output logic [7:0]  ERR_CNT
);

   localparam int TW =
      (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   ps2_state_e  state_q, state_d;
   logic [TW-1:0] tmo_q;
   logic [11:0] key_q, key_d;
   logic        ovf_q;
   logic [7:0]  err_q;
   logic        push;
   logic [4:0]  push_data;
   logic        pop;
   logic        full;
   logic        empty;
   logic        tmo_hit;
   key_hit_t    hit;

   assign hit     = code_to_idx(RX_DATA);
   assign tmo_hit = (state_q != IDLE) &&
                    (tmo_q == TW'(TIMEOUT_CYC - 1));
   assign pop     = ~empty & EVT_READY;

   // prefix decode, key state update and event generation
   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      push      = 1'b0;
      push_data = {hit.idx, 1'b1};
      if (RX_VALID && RX_ERR) begin
         state_d = IDLE;
      end else if (RX_VALID) begin
         unique case (state_q)
            IDLE: begin
               if (RX_DATA == PS2_EXT) begin
                  state_d = EXT;
               end else if (RX_DATA == PS2_BRK) begin
                  state_d = BRK;
               end else if (hit.vld) begin
                  if (!key_q[hit.idx]) begin
                     key_d[hit.idx] = 1'b1;
                     push           = 1'b1;
                  end else begin
                     push = REPEAT_EN;
                  end
               end
            end
            EXT: begin
               state_d = (RX_DATA == PS2_BRK) ?
                         EXT_BRK : IDLE;
            end
            BRK: begin
               state_d = IDLE;
               if (hit.vld && key_q[hit.idx]) begin
                  key_d[hit.idx] = 1'b0;
                  push           = 1'b1;
                  push_data      = {hit.idx, 1'b0};
               end
            end
            EXT_BRK: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else if (tmo_hit) begin
         state_d = IDLE;
      end
   end

   // state, key bitmap, timeout, overflow and error registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         key_q   <= '0;
         tmo_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= '0;
      end else if (CLEAR) begin
         state_q <= IDLE;
         key_q   <= '0;
         tmo_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         if (push && full && !pop) ovf_q <= 1'b1;
         if (RX_VALID && RX_ERR && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
         if (RX_VALID || state_q == IDLE || tmo_hit)
            tmo_q <= '0;
         else
            tmo_q <= tmo_q + TW'(1);
      end
   end

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (5)
   ) u_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .flush   (CLEAR),
      .push    (push),
      .pop     (pop),
      .wr_data (push_data),
      .rd_data ({EVT_KEY, EVT_MAKE}),
      .full    (full),
      .empty   (empty)
   );

   assign EVT_VALID = ~empty;
   assign KEY_STATE = key_q;
   assign OVERFLOW  = ovf_q;
   assign ERR_CNT   = err_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Randomised bench for ps2_key_event_ctrl: two DUTs
// (repeat off/on) against an event-level queue model.
module tb_ps2_key_event_ctrl;

   localparam int TMO   = 40;
   localparam int DEPTH = 4;
   localparam logic [7:0] CODES [12] = '{
      8'h15, 8'h1C, 8'h1D, 8'h1B,
      8'h24, 8'h23, 8'h2D, 8'h2B,
      8'h2C, 8'h34, 8'h35, 8'h33
   };

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       evt_ready;

   logic [1:0]  evt_valid;
   logic [1:0]  evt_make;
   logic [1:0]  overflow;
   logic [3:0]  evt_key   [2];
   logic [11:0] key_state [2];
   logic [7:0]  err_cnt   [2];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ps2_key_event_ctrl #(
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TMO),
      .REPEAT_EN   (1'b0)
   ) u_dut0 (
      .CLK       (clk),
      .RST_N     (rst_n),
      .CLEAR     (clear),
      .RX_VALID  (rx_valid),
      .RX_DATA   (rx_data),
      .RX_ERR    (rx_err),
      .EVT_VALID (evt_valid[0]),
      .EVT_READY (evt_ready),
      .EVT_KEY   (evt_key[0]),
      .EVT_MAKE  (evt_make[0]),
      .KEY_STATE (key_state[0]),
      .OVERFLOW  (overflow[0]),
      .ERR_CNT   (err_cnt[0])
   );

   ps2_key_event_ctrl #(
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TMO),
      .REPEAT_EN   (1'b1)
   ) u_dut1 (
      .CLK       (clk),
      .RST_N     (rst_n),
      .CLEAR     (clear),
      .RX_VALID  (rx_valid),
      .RX_DATA   (rx_data),
      .RX_ERR    (rx_err),
      .EVT_VALID (evt_valid[1]),
      .EVT_READY (evt_ready),
      .EVT_KEY   (evt_key[1]),
      .EVT_MAKE  (evt_make[1]),
      .KEY_STATE (key_state[1]),
      .OVERFLOW  (overflow[1]),
      .ERR_CNT   (err_cnt[1])
   );

   // ---------------- reference model ----------------
   // pend: 0 none, 1 after E0, 2 after F0, 3 after E0 F0
   logic [4:0]  mq0 [$];
   logic [4:0]  mq1 [$];
   int          pend [2];
   logic [11:0] held [2];
   bit          ovf  [2];
   int          errs [2];
   longint      last [2];
   longint      now = 0;

   function automatic int qsize(int r);
      return (r == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [4:0] qfront(int r);
      return (r == 0) ? mq0[0] : mq1[0];
   endfunction

   task automatic qpop(int r);
      if (r == 0) void'(mq0.pop_front());
      else        void'(mq1.pop_front());
   endtask

   task automatic qpush(int r, logic [4:0] v);
      if (qsize(r) >= DEPTH) ovf[r] = 1'b1;
      else if (r == 0) mq0.push_back(v);
      else mq1.push_back(v);
   endtask

   task automatic model_clear();
      mq0.delete();
      mq1.delete();
      for (int r = 0; r < 2; r++) begin
         pend[r] = 0;
         held[r] = '0;
         ovf[r]  = 1'b0;
         errs[r] = 0;
      end
   endtask

   function automatic int key_of(logic [7:0] b);
      for (int i = 0; i < 12; i++)
         if (CODES[i] == b) return i;
      return -1;
   endfunction

   task automatic model_edge(
      input bit clr, input bit rxv,
      input logic [7:0] d, input bit er,
      input bit rdy
   );
      int k;
      k = key_of(d);
      if (clr) begin
         model_clear();
      end else begin
         for (int r = 0; r < 2; r++) begin
            if (rdy && qsize(r) > 0) qpop(r);
            if (rxv && er) begin
               if (errs[r] < 255) errs[r]++;
               pend[r] = 0;
            end else if (rxv) begin
               if (pend[r] != 0 && now - last[r] > TMO)
                  pend[r] = 0;
               case (pend[r])
                  0: begin
                     if (d == 8'hE0) pend[r] = 1;
                     else if (d == 8'hF0) pend[r] = 2;
                     else if (k >= 0) begin
                        if (!held[r][k]) begin
                           held[r][k] = 1'b1;
                           qpush(r, {4'(k), 1'b1});
                        end else if (r == 1) begin
                           qpush(r, {4'(k), 1'b1});
                        end
                     end
                  end
                  1: pend[r] = (d == 8'hF0) ? 3 : 0;
                  2: begin
                     pend[r] = 0;
                     if (k >= 0 && held[r][k]) begin
                        held[r][k] = 1'b0;
                        qpush(r, {4'(k), 1'b0});
                     end
                  end
                  default: pend[r] = 0;
               endcase
               last[r] = now;
            end
         end
      end
      now++;
   endtask

   // ---------------- checking ----------------
   task automatic chk(
      input string tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
      end
   endtask

   task automatic check_all();
      string s;
      for (int r = 0; r < 2; r++) begin
         s = $sformatf("u%0d", r);
         chk({s, ".valid"}, 32'(evt_valid[r]),
             32'(qsize(r) != 0));
         if (qsize(r) != 0) begin
            chk({s, ".key"}, 32'(evt_key[r]),
                32'(qfront(r) >> 1));
            chk({s, ".make"}, 32'(evt_make[r]),
                32'(qfront(r) & 5'd1));
         end
         chk({s, ".key_state"}, 32'(key_state[r]),
             32'(held[r]));
         chk({s, ".overflow"}, 32'(overflow[r]),
             32'(ovf[r]));
         chk({s, ".err_cnt"}, 32'(err_cnt[r]),
             32'(errs[r]));
      end
   endtask

   task automatic check_reset_vals(input string t);
      for (int r = 0; r < 2; r++) begin
         chk({t, ".valid"}, 32'(evt_valid[r]), 0);
         chk({t, ".key"}, 32'(evt_key[r]), 0);
         chk({t, ".make"}, 32'(evt_make[r]), 0);
         chk({t, ".ks"}, 32'(key_state[r]), 0);
         chk({t, ".ovf"}, 32'(overflow[r]), 0);
         chk({t, ".err"}, 32'(err_cnt[r]), 0);
      end
   endtask

   // ---------------- stimulus ----------------
   // called at a negedge; returns at the next negedge
   task automatic cyc(
      input bit clr, input bit rxv,
      input logic [7:0] d, input bit er,
      input bit rdy
   );
      clear     = clr;
      rx_valid  = rxv;
      rx_data   = d;
      rx_err    = er;
      evt_ready = rdy;
      @(posedge clk);
      model_edge(clr, rxv, d, er, rdy);
      @(negedge clk);
      clear    = 1'b0;
      rx_valid = 1'b0;
      rx_err   = 1'b0;
      check_all();
   endtask

   task automatic send(input logic [7:0] b,
                       input bit rdy);
      cyc(1'b0, 1'b1, b, 1'b0, rdy);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 1'b0, 8'h00, 1'b0, rdy);
   endtask

   task automatic do_clear();
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   function automatic logic [7:0] rnd_byte();
      int k;
      k = $urandom_range(0, 99);
      if (k < 50) return CODES[$urandom_range(0, 11)];
      if (k < 65) return 8'hE0;
      if (k < 85) return 8'hF0;
      return 8'($urandom_range(0, 255));
   endfunction

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      rx_err    = 1'b0;
      evt_ready = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single make, held in FIFO
      send(8'h1C, 1'b0);
      chk("t1_rise", 32'(evt_valid[0]), 1);
      idle(10, 1'b0);
      chk("t1_ks", 32'(key_state[0]), 32'h002);
      do_clear();

      // make then break with consumer ready
      send(8'h1C, 1'b1);
      send(8'hF0, 1'b1);
      send(8'h1C, 1'b1);
      idle(3, 1'b1);
      chk("t2_ks", 32'(key_state[0]), 0);
      do_clear();

      // extended and unheld-break sequences
      send(8'hE0, 1'b0);
      send(8'h75, 1'b0);
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h75, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h2D, 1'b0);
      idle(2, 1'b0);
      chk("t3_valid", 32'(evt_valid[0]), 0);
      chk("t3_ks", 32'(key_state[0]), 0);
      do_clear();

      // overflow, then simultaneous push/pop while full
      send(8'h15, 1'b0);
      send(8'h1C, 1'b0);
      send(8'h1D, 1'b0);
      send(8'h1B, 1'b0);
      send(8'h24, 1'b0);
      idle(2, 1'b0);
      chk("t4_ovf", 32'(overflow[0]), 1);
      chk("t4_ks", 32'(key_state[0]), 32'h01F);
      send(8'h2C, 1'b1);
      idle(6, 1'b1);
      do_clear();

      // break prefix times out, error byte counted
      send(8'hF0, 1'b0);
      idle(TMO + 5, 1'b0);
      send(8'h15, 1'b0);
      chk("t5_key", 32'(evt_key[0]), 0);
      chk("t5_make", 32'(evt_make[0]), 1);
      cyc(1'b0, 1'b1, 8'h15, 1'b1, 1'b0);
      chk("t5_err", 32'(err_cnt[0]), 1);
      do_clear();

      // typematic repeat, then clear with data queued
      for (int i = 0; i < 3; i++) begin
         send(8'h15, 1'b0);
         idle(2, 1'b0);
      end
      do_clear();
      chk("t6_valid0", 32'(evt_valid[0]), 0);
      chk("t6_valid1", 32'(evt_valid[1]), 0);
      chk("t6_ks", 32'(key_state[1]), 0);

      // prefix pending across an asynchronous reset
      send(8'hF0, 1'b0);
      async_reset();
      send(8'h15, 1'b0);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) async_reset();
         if ($urandom_range(0, 199) == 0)
            idle(TMO + 3, $urandom_range(0, 2) == 0);
         else
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 2) == 0,
                rnd_byte(),
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               n_chk, n_fail);
      $finish;
   end

endmodule
